// File: rtl/fp_pkg.sv
// Shared constants and types for the FP normalise/round datapath:
// rounding-mode encodings, flag bit positions and guard/round/sticky width.
package fp_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_e;

    localparam int unsigned GRS_W     = 3;
    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned FLAG_OVF  = 3;
    localparam int unsigned FLAG_UNF  = 2;
    localparam int unsigned FLAG_INX  = 1;
    localparam int unsigned FLAG_ZERO = 0;

    function automatic logic round_up(input rnd_mode_e mode, input logic sign,
                                      input logic lsb, input logic g,
                                      input logic r, input logic s);
        logic up;
        case (mode)
            RND_RNE: up = g & (r | s | lsb);
            RND_RTZ: up = 1'b0;
            RND_RUP: up = ~sign & (g | r | s);
            RND_RDN: up = sign & (g | r | s);
            default: up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; count is 0 when the input is all zero,
// which is reported separately through all_zero.
module fp_lzc #(
    parameter int unsigned W  = 27,
    parameter int unsigned CW = $clog2(W)
) (
    input  logic [W-1:0]  in_vec,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // Scan upward so the highest set bit is the last one to assign the count.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (in_vec[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

    assign all_zero = ~|in_vec;

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage FP normalise/round/pack pipeline with valid/ready on both sides.
// Define FP_ROUND_MODES_EN to honour rnd_mode; otherwise RNE only.
module fp_norm_round_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+3:0]         in_mant,
    input  logic                     in_carry,
    input  logic [1:0]               rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [FLAG_W-1:0]        out_flags
);

    localparam int unsigned SIG_W = MAN_W + 1 + GRS_W;
    localparam int unsigned CW    = $clog2(SIG_W);
    localparam int unsigned EW2   = EXP_W + 2;
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;

    logic                  s1_valid;
    logic                  s1_sign;
    logic signed [EW2-1:0] s1_exp;
    logic [SIG_W-1:0]      s1_sig;
    logic                  s1_zero;
    rnd_mode_e             s1_rnd;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  s2_adv;
    rnd_mode_e             in_rnd;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = s1_valid & s2_adv;
    assign in_ready  = ~s1_valid | s1_adv;
    assign out_valid = s2_valid;

`ifdef FP_ROUND_MODES_EN
    assign in_rnd = rnd_mode_e'(rnd_mode);
`else
    logic unused_rnd_mode;
    assign unused_rnd_mode = ^rnd_mode;
    assign in_rnd = RND_RNE;
`endif

    // Stage 1: carry pre-shift or leading-zero normalisation.
    logic [CW-1:0]         lzc_cnt;
    logic                  lzc_zero;
    logic signed [EW2-1:0] n1_exp;
    logic [SIG_W-1:0]      n1_sig;

    fp_lzc #(.W(SIG_W), .CW(CW)) u_lzc (
        .in_vec   (in_mant),
        .count    (lzc_cnt),
        .all_zero (lzc_zero)
    );

    always_comb begin
        n1_exp = EW2'(in_exp);
        n1_sig = in_mant;
        if (in_carry) begin
            n1_sig = {1'b1, in_mant[SIG_W-1:2], |in_mant[1:0]};
            n1_exp = EW2'(in_exp) + EW2'(1);
        end else if (!in_mant[SIG_W-1]) begin
            n1_sig = in_mant << lzc_cnt;
            n1_exp = EW2'(in_exp) - EW2'(lzc_cnt);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_sig   <= '0;
            s1_zero  <= 1'b0;
            s1_rnd   <= RND_RNE;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sign <= in_sign;
                s1_exp  <= n1_exp;
                s1_sig  <= n1_sig;
                s1_zero <= ~in_carry & lzc_zero;
                s1_rnd  <= in_rnd;
            end
        end
    end

    // Stage 2: round, renormalise on carry-out, exceptions, pack.
    logic                  rnd_up;
    logic [MAN_W+1:0]      mant_r;
    logic signed [EW2-1:0] exp_f;
    logic [MAN_W-1:0]      frac;
    logic [EXP_W+MAN_W:0]  n2_result;
    logic [FLAG_W-1:0]     n2_flags;

    always_comb begin
        rnd_up = round_up(s1_rnd, s1_sign, s1_sig[GRS_W], s1_sig[2], s1_sig[1], s1_sig[0]);
        mant_r = {1'b0, s1_sig[SIG_W-1:GRS_W]} + (MAN_W+2)'(rnd_up);
        exp_f  = s1_exp + EW2'(mant_r[MAN_W+1]);
        frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        n2_flags           = '0;
        n2_flags[FLAG_INX] = |s1_sig[GRS_W-1:0];
        n2_result          = {s1_sign, exp_f[EXP_W-1:0], frac};

        if (s1_zero) begin
            n2_result           = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            n2_flags            = '0;
            n2_flags[FLAG_ZERO] = 1'b1;
        end else if (exp_f >= EXP_MAX) begin
            n2_result           = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            n2_flags            = '0;
            n2_flags[FLAG_OVF]  = 1'b1;
            n2_flags[FLAG_INX]  = 1'b1;
        end else if (exp_f <= EXP_ZERO) begin
            n2_result           = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            n2_flags            = '0;
            n2_flags[FLAG_UNF]  = 1'b1;
            n2_flags[FLAG_ZERO] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_result <= n2_result;
                out_flags  <= n2_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Scoreboard bench for fp_norm_round_pipe: directed beats with hand-computed
// results, stall/backpressure and mid-stream reset.
module tb_fp_norm_round_pipe;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_carry;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int errors = 0;
    int checks = 0;
    logic [35:0] sb[$];

    fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_carry   (in_carry),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic c, input logic [1:0] md,
                        input logic [31:0] er, input logic [3:0] ef);
        bit acc = 1'b0;
        int n = 0;
        in_sign = s; in_exp = e; in_mant = m; in_carry = c; rnd_mode = md;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back({er, ef});
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no in_ready expected accept within 50 cycles");
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pop one expectation per accepted output beat.
    always @(negedge clk) begin
        logic [35:0] e;
        if (!arst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: got result %h expected no beat", out_result);
            end else begin
                e = sb.pop_front();
                chk("sb_result", out_result, e[35:4]);
                chk("sb_flags", {28'd0, out_flags}, {28'd0, e[3:0]});
            end
        end
    end

    initial begin
        arst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_carry = 1'b0; rnd_mode = 2'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
        @(negedge clk) arst = 1'b0;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Normal beat plus latency
        send(1'b0, 8'h80, {1'b1, 23'h0, 3'b000}, 1'b0, 2'd0, 32'h40000000, 4'b0000);
        chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);

        send(1'b0, 8'h7F, {1'b1, 23'h7FFFFF, 3'b000}, 1'b1, 2'd0, 32'h40800000, 4'b0010);
        send(1'b0, 8'h85, 27'h0000010, 1'b0, 2'd0, 32'h37800000, 4'b0000);
        send(1'b1, 8'h85, 27'h0000000, 1'b0, 2'd0, 32'h80000000, 4'b0001);
        send(1'b0, 8'hFE, {1'b1, 23'h0, 3'b000}, 1'b1, 2'd0, 32'h7F800000, 4'b1010);
        send(1'b0, 8'h01, 27'h1000000, 1'b0, 2'd0, 32'h00000000, 4'b0101);
        send(1'b0, 8'h7F, {1'b1, 23'h000000, 3'b100}, 1'b0, 2'd0, 32'h3F800000, 4'b0010);
        send(1'b0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 1'b0, 2'd0, 32'h3F800002, 4'b0010);
`ifdef FP_ROUND_MODES_EN
        send(1'b0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 1'b0, 2'd1, 32'h3F800001, 4'b0010);
        send(1'b0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 1'b0, 2'd2, 32'h3F800002, 4'b0010);
        send(1'b1, 8'h7F, {1'b1, 23'h000001, 3'b100}, 1'b0, 2'd3, 32'hBF800002, 4'b0010);
        send(1'b1, 8'h7F, {1'b1, 23'h000001, 3'b100}, 1'b0, 2'd2, 32'hBF800001, 4'b0010);
`else
        send(1'b0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 1'b0, 2'd1, 32'h3F800002, 4'b0010);
`endif
        drain();

        // Backpressure: two beats fill the pipe, then input stalls
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++)
            send(1'b0, 8'(8'h80 + i), {1'b1, 23'h0, 3'b000}, 1'b0, 2'd0,
                 {1'b0, 8'(8'h80 + i), 23'd0}, 4'b0000);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("stall_hold", out_result, 32'h40000000);
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 2; i < 5; i++)
                    send(1'b0, 8'(8'h80 + i), {1'b1, 23'h0, 3'b000}, 1'b0, 2'd0,
                         {1'b0, 8'(8'h80 + i), 23'd0}, 4'b0000);
            end
        join
        drain();

        // Mid-stream reset discards parked beats
        out_ready = 1'b0;
        send(1'b0, 8'h81, {1'b1, 23'h0, 3'b000}, 1'b0, 2'd0, 32'h40800000, 4'b0000);
        send(1'b0, 8'h82, {1'b1, 23'h0, 3'b000}, 1'b0, 2'd0, 32'h41000000, 4'b0000);
        #2 arst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        chk("arst_out_flags", {28'd0, out_flags}, 32'd0);
        sb.delete();
        @(negedge clk) arst = 1'b0;
        out_ready = 1'b1;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(1'b1, 8'h90, {1'b1, 23'h400000, 3'b000}, 1'b0, 2'd0, 32'hC8400000, 4'b0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
